// File: rtl/fetch_stage_pkg.sv
// Shared constants for the IF stage: NOP encoding, FSM states, default widths.
package fetch_stage_pkg;
  localparam int NB_PC_DEF   = 32;
  localparam int NB_INST_DEF = 32;
  localparam int NB_DATA_DEF = 32;
  localparam int NB_ADDR_DEF = 8;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_imem.sv
// Instruction memory: one synchronous write port (Debug Unit), one combinational read port.
module fetch_stage_imem #(
  parameter int NB_ADDR = 8,
  parameter int NB_INST = 32
) (
  input  logic               i_clock,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_INST-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_INST-1:0] o_rdata
);
  logic [NB_INST-1:0] mem [2**NB_ADDR];

  // Not reset: contents survive a pipeline reset so a loaded program can rerun.
  always_ff @(posedge i_clock) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC selection, IF/ID latch and RUN/HALTED FSM.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int NB_PC   = NB_PC_DEF,
  parameter int NB_INST = NB_INST_DEF,
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_pipeline_enable,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [NB_PC-1:0]   i_branch_addr,
  input  logic               i_jr_jalr,
  input  logic [NB_DATA-1:0] i_jr_addr,
  input  logic               i_jump,
  input  logic [NB_PC-1:0]   i_jump_addr,
  input  logic               i_halt,
  input  logic               i_dbg_mem_we,
  input  logic [NB_ADDR-1:0] i_dbg_mem_addr,
  input  logic [NB_INST-1:0] i_dbg_mem_data,
  output logic [NB_INST-1:0] o_inst,
  output logic [NB_PC-1:0]   o_pc,
  output logic [NB_PC-1:0]   o_pc_fetch,
  output logic               o_halted
);
  fetch_state_e       state_q, state_d;
  logic [NB_PC-1:0]   pc_q, pc_d, pc_inc;
  logic [NB_PC-1:0]   ifid_pc_q, ifid_pc_d;
  logic [NB_INST-1:0] ifid_inst_q, ifid_inst_d;
  logic               halted_q, halted_d;
  logic [NB_INST-1:0] mem_rdata;
  logic               redirect;
  logic [NB_PC-1:0]   target;

  fetch_stage_imem #(
    .NB_ADDR (NB_ADDR),
    .NB_INST (NB_INST)
  ) u_imem (
    .i_clock (i_clock),
    .i_we    (i_dbg_mem_we),
    .i_waddr (i_dbg_mem_addr),
    .i_wdata (i_dbg_mem_data),
    .i_raddr (pc_q[NB_ADDR-1:0]),
    .o_rdata (mem_rdata)
  );

  assign pc_inc = pc_q + NB_PC'(1);

  always_comb begin
    redirect = i_branch_taken | i_jr_jalr | i_jump;
    if (i_branch_taken) target = i_branch_addr;
    else if (i_jr_jalr) target = i_jr_addr[NB_PC-1:0];
    else                target = i_jump_addr;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_inst_d = ifid_inst_q;
    ifid_pc_d   = ifid_pc_q;
    halted_d    = halted_q;
    if (i_pipeline_enable && state_q == ST_RUN) begin
      // A taken branch means the HALT came from the wrong path, so it is dropped.
      if (i_halt && !i_branch_taken && !i_stall) begin
        state_d     = ST_HALTED;
        halted_d    = 1'b1;
        ifid_inst_d = NB_INST'(NOP);
        ifid_pc_d   = '0;
      end else if (redirect) begin
        pc_d        = target;
        ifid_inst_d = NB_INST'(NOP);
        ifid_pc_d   = '0;
      end else if (!i_stall) begin
        pc_d        = pc_inc;
        ifid_inst_d = mem_rdata;
        ifid_pc_d   = pc_inc;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      ifid_inst_q <= NB_INST'(NOP);
      ifid_pc_q   <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ifid_inst_q <= ifid_inst_d;
      ifid_pc_q   <= ifid_pc_d;
      halted_q    <= halted_d;
    end
  end

  assign o_inst     = ifid_inst_q;
  assign o_pc       = ifid_pc_q;
  assign o_pc_fetch = pc_q;
  assign o_halted   = halted_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random traffic vs a model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, stall, br, jr, jmp, halt, we;
  logic [31:0] br_addr, jr_addr, jmp_addr, wdata;
  logic [7:0]  waddr;
  logic [31:0] o_inst, o_pc, o_pc_fetch;
  logic        o_halted;

  fetch_stage dut (
    .i_clock           (clk),
    .i_reset           (rst_n),
    .i_pipeline_enable (en),
    .i_stall           (stall),
    .i_branch_taken    (br),
    .i_branch_addr     (br_addr),
    .i_jr_jalr         (jr),
    .i_jr_addr         (jr_addr),
    .i_jump            (jmp),
    .i_jump_addr       (jmp_addr),
    .i_halt            (halt),
    .i_dbg_mem_we      (we),
    .i_dbg_mem_addr    (waddr),
    .i_dbg_mem_data    (wdata),
    .o_inst            (o_inst),
    .o_pc              (o_pc),
    .o_pc_fetch        (o_pc_fetch),
    .o_halted          (o_halted)
  );

  // Reference model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_inst, m_opc;
  logic        m_halted;

  int          n_tests = 0, n_fail = 0;
  bit          chk_en = 1'b0;
  bit          lit_on = 1'b0;
  logic [31:0] l_inst, l_opc, l_pcf;
  logic        l_halted;
  string       l_name;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model.o_inst", o_inst, m_inst);
      check("model.o_pc", o_pc, m_opc);
      check("model.o_pc_fetch", o_pc_fetch, m_pc);
      check("model.o_halted", {31'b0, o_halted}, {31'b0, m_halted});
      if (lit_on) begin
        check({l_name, ".o_inst"}, o_inst, l_inst);
        check({l_name, ".o_pc"}, o_pc, l_opc);
        check({l_name, ".o_pc_fetch"}, o_pc_fetch, l_pcf);
        check({l_name, ".o_halted"}, {31'b0, o_halted}, {31'b0, l_halted});
      end
    end
  end

  task automatic idle();
    rst_n = 1'b1; en = 1'b1; stall = 1'b0; br = 1'b0; jr = 1'b0; jmp = 1'b0;
    halt = 1'b0; we = 1'b0; br_addr = '0; jr_addr = '0; jmp_addr = '0;
    wdata = '0; waddr = '0;
  endtask

  // Apply current inputs for one clock, advancing the model from the rules.
  task automatic cycle();
    logic [31:0] npc, ninst, nopc, fetched;
    logic        nh;
    npc = m_pc; ninst = m_inst; nopc = m_opc; nh = m_halted;
    fetched = m_mem[m_pc[7:0]];
    if (!rst_n) begin
      npc = 0; ninst = 0; nopc = 0; nh = 1'b0;
    end else if (en && !m_halted) begin
      if (br)                 begin npc = br_addr;  ninst = 0; nopc = 0; end
      else if (halt && !stall) begin nh = 1'b1;     ninst = 0; nopc = 0; end
      else if (jr)            begin npc = jr_addr;  ninst = 0; nopc = 0; end
      else if (jmp)           begin npc = jmp_addr; ninst = 0; nopc = 0; end
      else if (!stall)        begin npc = m_pc + 1; ninst = fetched; nopc = m_pc + 1; end
    end
    @(posedge clk);
    #1;
    if (we) m_mem[waddr] = wdata;
    m_pc = npc; m_inst = ninst; m_opc = nopc; m_halted = nh;
  endtask

  task automatic expect_lit(string nm, logic [31:0] inst, logic [31:0] opc,
                            logic [31:0] pcf, logic h);
    l_name = nm; l_inst = inst; l_opc = opc; l_pcf = pcf; l_halted = h;
    lit_on = 1'b1;
    @(negedge clk);
    #1;
    lit_on = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    idle();
    rst_n = 1'b0;
    m_pc = 0; m_inst = 0; m_opc = 0; m_halted = 0;
    // Preload the whole memory (with reset held) so every fetch has a known value.
    for (int i = 0; i < 256; i++) begin
      case (i)
        0:       v = 32'hA000_000A;
        1:       v = 32'hB000_000B;
        2:       v = 32'hC000_000C;
        3:       v = 32'hD000_000D;
        'h10:    v = 32'h1111_0010;
        'h20:    v = 32'h2222_0020;
        'h21:    v = 32'h2222_0021;
        default: v = $urandom;
      endcase
      we = 1'b1; waddr = 8'(i); wdata = v;
      cycle();
      chk_en = 1'b1;
    end
    we = 1'b0;
    expect_lit("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    // Sequential fetch
    idle();
    cycle(); expect_lit("seqA", 32'hA000_000A, 1, 1, 0);
    cycle(); expect_lit("seqB", 32'hB000_000B, 2, 2, 0);
    cycle(); expect_lit("seqC", 32'hC000_000C, 3, 3, 0);
    cycle(); expect_lit("seqD", 32'hD000_000D, 4, 4, 0);

    // Jump while B in IF/ID
    rst_n = 1'b0; cycle(); idle();
    cycle(); cycle();
    jmp = 1'b1; jmp_addr = 32'h10; cycle(); idle();
    expect_lit("jump_squash", 32'h0, 0, 32'h10, 0);
    cycle(); expect_lit("jump_target", 32'h1111_0010, 32'h11, 32'h11, 0);

    // Branch beats jump and stall
    br = 1'b1; br_addr = 32'h20; jmp = 1'b1; jmp_addr = 32'h10; stall = 1'b1;
    cycle(); idle();
    expect_lit("branch_prio", 32'h0, 0, 32'h20, 0);
    cycle(); expect_lit("after_branch", 32'h2222_0020, 32'h21, 32'h21, 0);

    // Stall holds for 3 cycles
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(); expect_lit("stall_hold", 32'h2222_0020, 32'h21, 32'h21, 0);
    end
    idle();
    cycle(); expect_lit("stall_release", 32'h2222_0021, 32'h22, 32'h22, 0);

    // Halt together with a taken branch: branch wins
    halt = 1'b1; br = 1'b1; br_addr = 32'h30; cycle(); idle();
    expect_lit("halt_vs_branch", 32'h0, 0, 32'h30, 0);

    // Halt, then redirect/stall ignored, then reset
    halt = 1'b1; cycle(); idle();
    expect_lit("halt", 32'h0, 0, 32'h30, 1);
    jmp = 1'b1; jmp_addr = 32'h10; stall = 1'b1; cycle(); idle();
    expect_lit("halt_frozen", 32'h0, 0, 32'h30, 1);
    rst_n = 1'b0; cycle(); idle();
    expect_lit("halt_reset", 32'h0, 0, 0, 0);

    // Pipeline disabled while Debug Unit writes mem[5]
    for (int k = 0; k < 4; k++) begin
      idle(); en = 1'b0;
      if (k == 1) begin we = 1'b1; waddr = 8'd5; wdata = 32'h5555_0005; end
      cycle(); expect_lit("disabled_hold", 32'h0, 0, 0, 0);
    end
    idle(); jmp = 1'b1; jmp_addr = 32'h5; cycle(); idle();
    cycle(); expect_lit("dbg_write_seen", 32'h5555_0005, 6, 6, 0);

    // PC wrap at the top of the address space
    jmp = 1'b1; jmp_addr = 32'hFFFF_FFFF; cycle(); idle();
    cycle(); expect_lit("pc_wrap", m_mem[255], 0, 0, 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst_n    = ($urandom_range(0, 59) != 0);
      en       = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      br       = ($urandom_range(0, 11) == 0);
      jr       = ($urandom_range(0, 11) == 0);
      jmp      = ($urandom_range(0, 11) == 0);
      halt     = ($urandom_range(0, 49) == 0);
      br_addr  = $urandom;
      jr_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
      jmp_addr = $urandom;
      we       = ($urandom_range(0, 9) == 0);
      waddr    = ($urandom_range(0, 1) == 0) ? m_pc[7:0] : 8'($urandom);
      wdata    = $urandom;
      cycle();
    end
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
